fir_ch_sched: RTL and testbench

- Two-channel scheduler that time-shares one serial 16-tap FIR MAC engine between two independent sample streams.
- Each channel has its own 1-entry input buffer and TAPS-deep sample history. Channels are granted in round-robin order.
- For each granted sample, the block sequences the engine through all taps, then presents the scaled result with a channel tag through a valid/ready output port.
- It sits between the sample sources and the shared MAC/coefficient-ROM datapath.

---
 rtl/fir_ch_sched_pkg.sv | 7 +
 rtl/fir_hist_buf.sv | 41 ++++
 rtl/fir_ch_sched.sv | 93 +++++++++
 tb/tb_fir_ch_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ch_sched_pkg.sv
// fir_sched_pkg: shared constants and FSM state type for the two-channel FIR scheduler
package fir_sched_pkg;
  localparam int NCH = 2;
  localparam int TAPS_DEF = 16;
  localparam int TAPS_W = $clog2(TAPS_DEF);
  typedef enum logic [1:0] {IDLE, RUN, WAIT, OUT} state_t;
endpackage

// File: rtl/fir_hist_buf.sv
// fir_hist_buf: one-entry sample buffer feeding a TAPS-deep sample history with a tap-indexed read port
//   x_valid/x : sample offered; taken whenever the buffer is empty (pend=0)
//   pend      : buffer holds a sample waiting for a grant
//   grant     : shift buffered sample into hist[0] and free the buffer
//   tap/rd    : combinational read of hist[tap]
module fir_hist_buf
  import fir_sched_pkg::*;
#(
  parameter int N = 32,
  parameter int TAPS = TAPS_DEF,
  parameter int TW = TAPS_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          x_valid,
  input  logic [N-1:0]  x,
  output logic          pend,
  input  logic          grant,
  input  logic [TW-1:0] tap,
  output logic [N-1:0]  rd
);
  logic [N-1:0] smp;
  logic [N-1:0] hist [TAPS];
  assign rd = hist[tap];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend <= 1'b0;
      smp <= '0;
      for (int i = 0; i < TAPS; i++) hist[i] <= '0;
    end else begin
      if (x_valid && !pend) begin
        pend <= 1'b1;
        smp <= x;
      end
      if (grant) begin
        pend <= 1'b0;
        hist[0] <= smp;
        for (int i = 1; i < TAPS; i++) hist[i] <= hist[i-1];
      end
    end
endmodule

// File: rtl/fir_ch_sched.sv
// fir_ch_sched: time-shares one serial FIR MAC engine between two sample channels
//   ch*_valid/ready/x : per-channel sample input, one-entry buffer each
//   mac_en/clr/tap/data, mac_acc : drive and read back the shared MAC engine
//   out_valid/ready/ch/y : scaled result (mac_acc >>> SHIFT) tagged with its channel
//   busy : FSM not idle
//   Build option FIR_CH_SCHED_FIXED_PRIO_EN: channel 0 always wins ties (no round-robin)
module fir_ch_sched
  import fir_sched_pkg::*;
#(
  parameter int N = 32,
  parameter int TAPS = TAPS_DEF,
  parameter int SHIFT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ch0_valid,
  output logic                     ch0_ready,
  input  logic [N-1:0]             ch0_x,
  input  logic                     ch1_valid,
  output logic                     ch1_ready,
  input  logic [N-1:0]             ch1_x,
  output logic                     mac_en,
  output logic                     mac_clr,
  output logic [$clog2(TAPS)-1:0]  mac_tap,
  output logic [N-1:0]             mac_data,
  input  logic [N-1:0]             mac_acc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_ch,
  output logic [N-1:0]             out_y,
  output logic                     busy
);
  localparam int TW = $clog2(TAPS);
  state_t state, nxt;
  logic [TW-1:0] cnt;
  logic cur_ch, sel, any;
  logic [NCH-1:0] pend, grant;
  logic [N-1:0] rd0, rd1;
  fir_hist_buf #(.N(N), .TAPS(TAPS), .TW(TW)) u_hb0 (
    .clk(clk), .rst(rst), .x_valid(ch0_valid), .x(ch0_x), .pend(pend[0]),
    .grant(grant[0]), .tap(cnt), .rd(rd0)
  );
  fir_hist_buf #(.N(N), .TAPS(TAPS), .TW(TW)) u_hb1 (
    .clk(clk), .rst(rst), .x_valid(ch1_valid), .x(ch1_x), .pend(pend[1]),
    .grant(grant[1]), .tap(cnt), .rd(rd1)
  );
  assign ch0_ready = !pend[0];
  assign ch1_ready = !pend[1];
  assign any = |pend;
`ifdef FIR_CH_SCHED_FIXED_PRIO_EN
  assign sel = !pend[0];
`else
  logic rr_last;
  // on a tie the channel not served last wins; otherwise the lone pending one
  assign sel = &pend ? !rr_last : pend[1];
  always_ff @(posedge clk or posedge rst)
    if (rst) rr_last <= 1'b1;
    else if (state == OUT && out_ready) rr_last <= cur_ch;
`endif
  assign grant = (state == IDLE && any) ? (sel ? 2'b10 : 2'b01) : 2'b00;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (any ? RUN : IDLE) :
          state == RUN  ? (cnt == TW'(TAPS - 1) ? WAIT : RUN) :
          state == WAIT ? OUT :
          (out_ready ? IDLE : OUT);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      cur_ch <= 1'b0;
      out_valid <= 1'b0;
      out_ch <= 1'b0;
      out_y <= '0;
    end else begin
      cnt <= state == RUN ? cnt + 1'b1 : '0;
      if (|grant) cur_ch <= sel;
      if (state == WAIT) begin
        out_y <= $signed(mac_acc) >>> SHIFT;
        out_ch <= cur_ch;
        out_valid <= 1'b1;
      end
      if (state == OUT && out_ready) out_valid <= 1'b0;
    end
  always_comb begin
    mac_en = state == RUN;
    mac_clr = mac_en && cnt == '0;
    mac_tap = mac_en ? cnt : '0;
    mac_data = mac_en ? (cur_ch ? rd1 : rd0) : '0;
    busy = state != IDLE;
  end
endmodule

// File: tb/tb_fir_ch_sched.sv
// tb_fir_ch_sched: directed and randomized checks of fir_ch_sched against a sum-of-products reference
module tb_fir_ch_sched;
  import fir_sched_pkg::*;
  localparam int N = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic ch0_valid = 1'b0, ch1_valid = 1'b0, ch0_ready, ch1_ready;
  logic [N-1:0] ch0_x = '0, ch1_x = '0;
  logic mac_en, mac_clr, out_valid, out_ch, busy;
  logic out_ready = 1'b0;
  logic [TAPS_W-1:0] mac_tap;
  logic [N-1:0] mac_data, mac_acc, out_y;
  longint coef [16];
  longint hist_m [2][16];
  longint q0 [$], q1 [$];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  fir_ch_sched dut (
    .clk(clk), .rst(rst),
    .ch0_valid(ch0_valid), .ch0_ready(ch0_ready), .ch0_x(ch0_x),
    .ch1_valid(ch1_valid), .ch1_ready(ch1_ready), .ch1_x(ch1_x),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_tap(mac_tap), .mac_data(mac_data), .mac_acc(mac_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_y(out_y), .busy(busy)
  );
  // stand-in for the shared MAC engine and coefficient ROM
  always @(posedge clk)
    if (mac_en)
      mac_acc <= N'((mac_clr ? 64'sd0 : longint'($signed(mac_acc))) + coef[mac_tap] * longint'($signed(mac_data)));
  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // reference: y = wrap32(sum c[i]*x[n-i]) >>> 16 over the channel's last 16 samples
  function automatic longint model_push(input int c, input longint x);
    longint sum;
    logic signed [31:0] a;
    for (int i = 15; i > 0; i--) hist_m[c][i] = hist_m[c][i-1];
    hist_m[c][0] = x;
    sum = 0;
    for (int i = 0; i < 16; i++) sum += coef[i] * hist_m[c][i];
    a = sum[31:0];
    return longint'(a >>> 16);
  endfunction
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic set_coef(input longint c0, input longint rest, input longint c1);
    for (int i = 0; i < 16; i++) coef[i] = rest;
    coef[0] = c0;
    coef[1] = c1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick;
    rst = 1'b0;
    tick;
    for (int c = 0; c < 2; c++) for (int i = 0; i < 16; i++) hist_m[c][i] = 0;
  endtask
  task automatic offer(input bit v0, input longint x0, input bit v1, input longint x1);
    ch0_valid = v0;
    ch0_x = N'(x0);
    ch1_valid = v1;
    ch1_x = N'(x1);
    tick;
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
  endtask
  task automatic wait_valid(input string tag);
    int k;
    for (k = 0; k < 100 && !out_valid; k++) tick;
    if (k == 100) chk({tag, "_timeout"}, 0, 1);
  endtask
  task automatic get_result(output bit c, output longint y);
    out_ready = 1'b1;
    wait_valid("res");
    c = out_ch;
    y = longint'($signed(out_y));
    tick;
    out_ready = 1'b0;
  endtask
  task automatic expect_res(input string tag, input bit ec, input longint ey);
    bit c;
    longint y;
    get_result(c, y);
    chk({tag, "_ch"}, c, ec);
    chk({tag, "_y"}, y, ey);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, en, clr, k;
    bit c;
    longint y, e;
    logic [N-1:0] hold_y;
    do_reset;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_mac_en", mac_en, 0);
    chk("rst_mac_clr", mac_clr, 0);
    chk("rst_mac_tap", mac_tap, 0);
    chk("rst_mac_data", mac_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ch0_ready", ch0_ready, 1);
    chk("rst_ch1_ready", ch1_ready, 1);
    // single sample, identity filter: latency and MAC sequencing
    set_coef(65536, 0, 0);
    ch0_valid = 1'b1;
    ch0_x = 100;
    lat = 0;
    en = 0;
    clr = 0;
    for (k = 1; k <= 40; k++) begin
      tick;
      ch0_valid = 1'b0;
      if (mac_en) begin
        if (mac_clr) begin
          clr++;
          chk("clr_first", en, 0);
        end
        chk("tap_seq", mac_tap, en);
        en++;
      end
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk("latency", lat, 19);
    chk("mac_en_cnt", en, 16);
    chk("mac_clr_cnt", clr, 1);
    expect_res("id100", 0, 100);
    // round-robin ordering
    do_reset;
    offer(1, 7, 1, -5);
    expect_res("pairA0", 0, 7);
    expect_res("pairA1", 1, -5);
    offer(1, 9, 0, 0);
    expect_res("single", 0, 9);
    offer(1, 11, 1, -3);
`ifdef FIR_CH_SCHED_FIXED_PRIO_EN
    expect_res("pairB0", 0, 11);
    expect_res("pairB1", 1, -3);
`else
    expect_res("pairB0", 1, -3);
    expect_res("pairB1", 0, 11);
`endif
    // moving sum over 16 taps, channel isolation
    do_reset;
    set_coef(65536, 65536, 65536);
    for (int s = 1; s <= 17; s++) begin
      offer(1, s, 0, 0);
      expect_res("msum", 0, s <= 16 ? s * (s + 1) / 2 : 152);
    end
    offer(0, 0, 1, 1000);
    expect_res("ch1_iso", 1, 1000);
    // output stall
    do_reset;
    set_coef(65536, 0, 0);
    offer(1, 42, 0, 0);
    wait_valid("stall");
    hold_y = out_y;
    offer(0, 0, 1, 77);
    chk("stall_ch1_ready", ch1_ready, 0);
    offer(1, 43, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_y", out_y, hold_y);
      chk("stall_ch", out_ch, 0);
      chk("stall_no_grant", mac_en, 0);
      tick;
    end
    chk("stall_y42", hold_y, 42);
    expect_res("stall_r0", 0, 42);
`ifdef FIR_CH_SCHED_FIXED_PRIO_EN
    expect_res("stall_r1", 0, 43);
    expect_res("stall_r2", 1, 77);
`else
    expect_res("stall_r1", 1, 77);
    expect_res("stall_r2", 0, 43);
`endif
    // negative accumulator rounds toward minus infinity
    do_reset;
    set_coef(65536, 0, 1);
    offer(1, -1, 0, 0);
    expect_res("neg1", 0, -1);
    offer(1, -1, 0, 0);
    expect_res("neg2", 0, -2);
    // reset in the middle of RUN
    do_reset;
    set_coef(65536, 0, 0);
    offer(1, 500, 1, 600);
    for (k = 0; k < 100 && !(mac_en && mac_tap == 8); k++) tick;
    chk("reach_tap8", k < 100, 1);
    rst = 1'b1;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_mac_en", mac_en, 0);
    chk("mrst_mac_clr", mac_clr, 0);
    chk("mrst_mac_tap", mac_tap, 0);
    chk("mrst_mac_data", mac_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ch0_ready", ch0_ready, 1);
    chk("mrst_ch1_ready", ch1_ready, 1);
    tick;
    rst = 1'b0;
    tick;
    set_coef(65536, 0, 65536);
    offer(1, 33, 0, 0);
    expect_res("after_rst", 0, 33);
    // randomized traffic with random coefficients and back-pressure
    do_reset;
    for (int i = 0; i < 16; i++) coef[i] = longint'($urandom_range(200000, 0)) - 100000;
    q0.delete();
    q1.delete();
    for (int cyc = 0; cyc < 3200; cyc++) begin
      bit drain;
      drain = cyc >= 3000;
      ch0_valid = !drain && $urandom_range(1, 0) == 1;
      ch1_valid = !drain && $urandom_range(3, 0) != 0;
      ch0_x = $urandom;
      ch1_x = $urandom;
      out_ready = drain || $urandom_range(3, 0) != 0;
      if (out_valid && out_ready) begin
        if (out_ch ? q1.size() == 0 : q0.size() == 0) chk("rnd_unexpected", 1, 0);
        else begin
          e = out_ch ? q1.pop_front() : q0.pop_front();
          chk(out_ch ? "rnd_y1" : "rnd_y0", $signed(out_y), e);
        end
      end
      if (ch0_valid && ch0_ready) q0.push_back(model_push(0, longint'($signed(ch0_x))));
      if (ch1_valid && ch1_ready) q1.push_back(model_push(1, longint'($signed(ch1_x))));
      tick;
    end
    chk("rnd_drain", q0.size() + q1.size(), 0);
    chk("rnd_idle", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
